// File: rtl/pong_ball.sv
`default_nettype none
// ============================================================================
// pong_ball : per-frame ball motion, wall/paddle bounces, serve/score sequencing
// Rev 1.0
// ============================================================================
module pong_ball #(
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int BALL_SIZE      = 8,
   parameter int PADDLE_W       = 8,
   parameter int PADDLE_H       = 64,
   parameter int LEFT_PADDLE_X  = 16,
   parameter int RIGHT_PADDLE_X = 616,
   parameter int SPEED          = 2,
   parameter int SERVE_DELAY    = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [9:0] player_y_pos,
   input  logic [9:0] cpu_y_pos,
   output logic [9:0] ball_x_pos,
   output logic [9:0] ball_y_pos,
   output logic       in_play,
   output logic       score_left,
   output logic       score_right
);

   localparam logic [9:0] c_XC      = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0] c_YC      = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0] c_YMAX    = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0] c_LFACE   = 10'(LEFT_PADDLE_X + PADDLE_W);
   localparam logic [9:0] c_RFACE   = 10'(RIGHT_PADDLE_X - BALL_SIZE);
   localparam logic [9:0] c_XMAX    = 10'(SCREEN_W - BALL_SIZE);
   localparam logic [9:0] c_SPD     = 10'(SPEED);
   localparam logic [9:0] c_Y_TURN  = c_YMAX - c_SPD;
   localparam logic [9:0] c_RHIT_LO = c_RFACE - c_SPD;
   localparam logic [9:0] c_LHIT_HI = c_LFACE + c_SPD;
   localparam logic [9:0] c_XMISS   = c_XMAX - c_SPD;
   localparam logic [10:0] c_BALL   = 11'(BALL_SIZE);
   localparam logic [10:0] c_PAD_H  = 11'(PADDLE_H);
   localparam int c_CNT_W = $clog2(SERVE_DELAY + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SERVE_DELAY - 1);

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_SCORE = 2'd2
   } state_t;

   state_t             r_state, w_state_n;
   logic [9:0]         r_x, w_x_n;
   logic [9:0]         r_y, w_y_n;
   logic               r_dx, w_dx_n;          // 1 = moving right
   logic               r_dy, w_dy_n;          // 1 = moving down
   logic               r_serve_dir, w_serve_dir_n;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_n;
   logic               r_in_play, w_in_play_n;
   logic               r_score_l, w_score_l_n;
   logic               r_score_r, w_score_r_n;
   logic               w_miss;

   // Overlap is computed one bit wider so paddle_y + PADDLE_H never wraps.
   logic [10:0] w_y_ext, w_cpu_ext, w_ply_ext;
   logic        w_ovl_cpu, w_ovl_ply;

   assign w_y_ext   = {1'b0, r_y};
   assign w_cpu_ext = {1'b0, cpu_y_pos};
   assign w_ply_ext = {1'b0, player_y_pos};
   assign w_ovl_cpu = (w_y_ext + c_BALL > w_cpu_ext) && (w_y_ext < w_cpu_ext + c_PAD_H);
   assign w_ovl_ply = (w_y_ext + c_BALL > w_ply_ext) && (w_y_ext < w_ply_ext + c_PAD_H);

   always_comb begin
      w_state_n     = r_state;
      w_x_n         = r_x;
      w_y_n         = r_y;
      w_dx_n        = r_dx;
      w_dy_n        = r_dy;
      w_serve_dir_n = r_serve_dir;
      w_cnt_n       = r_cnt;
      w_in_play_n   = r_in_play;
      w_score_l_n   = 1'b0;
      w_score_r_n   = 1'b0;
      w_miss        = 1'b0;

      if (frame_tick) begin
         case (r_state)
            ST_SERVE: begin
               if (r_cnt == c_CNT_LAST) begin
                  w_cnt_n     = '0;
                  w_dx_n      = r_serve_dir;
                  w_dy_n      = 1'b1;
                  w_state_n   = ST_PLAY;
                  w_in_play_n = 1'b1;
               end else begin
                  w_cnt_n = r_cnt + c_CNT_W'(1);
               end
            end

            ST_PLAY: begin
               if (r_dy) begin
                  if (r_y >= c_Y_TURN) begin
                     w_y_n  = c_YMAX;
                     w_dy_n = 1'b0;
                  end else begin
                     w_y_n = r_y + c_SPD;
                  end
               end else begin
                  if (r_y <= c_SPD) begin
                     w_y_n  = '0;
                     w_dy_n = 1'b1;
                  end else begin
                     w_y_n = r_y - c_SPD;
                  end
               end

               if (r_dx) begin
                  if (r_x >= c_RHIT_LO && r_x <= c_RFACE && w_ovl_cpu) begin
                     w_x_n  = c_RFACE;
                     w_dx_n = 1'b0;
                  end else if (r_x >= c_XMISS) begin
                     w_miss        = 1'b1;
                     w_score_l_n   = 1'b1;
                     w_serve_dir_n = 1'b1;
                  end else begin
                     w_x_n = r_x + c_SPD;
                  end
               end else begin
                  if (r_x >= c_LFACE && r_x <= c_LHIT_HI && w_ovl_ply) begin
                     w_x_n  = c_LFACE;
                     w_dx_n = 1'b1;
                  end else if (r_x <= c_SPD) begin
                     w_miss        = 1'b1;
                     w_score_r_n   = 1'b1;
                     w_serve_dir_n = 1'b0;
                  end else begin
                     w_x_n = r_x - c_SPD;
                  end
               end

               // The ball freezes in place on the scoring tick.
               if (w_miss) begin
                  w_x_n     = r_x;
                  w_y_n     = r_y;
                  w_dy_n    = r_dy;
                  w_state_n = ST_SCORE;
               end
            end

            ST_SCORE: begin
               w_x_n       = c_XC;
               w_y_n       = c_YC;
               w_in_play_n = 1'b0;
               w_state_n   = ST_SERVE;
            end

            default: begin
               w_state_n = ST_SERVE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SERVE;
         r_x         <= c_XC;
         r_y         <= c_YC;
         r_dx        <= 1'b1;
         r_dy        <= 1'b1;
         r_serve_dir <= 1'b1;
         r_cnt       <= '0;
         r_in_play   <= 1'b0;
         r_score_l   <= 1'b0;
         r_score_r   <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_x         <= w_x_n;
         r_y         <= w_y_n;
         r_dx        <= w_dx_n;
         r_dy        <= w_dy_n;
         r_serve_dir <= w_serve_dir_n;
         r_cnt       <= w_cnt_n;
         r_in_play   <= w_in_play_n;
         r_score_l   <= w_score_l_n;
         r_score_r   <= w_score_r_n;
      end
   end

   assign ball_x_pos  = r_x;
   assign ball_y_pos  = r_y;
   assign in_play     = r_in_play;
   assign score_left  = r_score_l;
   assign score_right = r_score_r;

endmodule
`default_nettype wire
